k423_if_bpu_v2: RTL and testbench
=================================

Name: k423_if_bpu_v2

Overview:
Parametrised next-generation branch predictor for the IF stage. It combines a gshare/bimodal BHT, a tagged direct-mapped BTB for indirect jumps, a speculative global history register (GHR), and a checkpointed return address stack (RAS). Prediction is combinational from registered state. Speculative GHR/RAS updates happen at prediction time and are repaired on mispredict using checkpoints carried down the pipe.

Parameters:
ADDR_W, 32, PC/target width
BHT_ENTRIES, 64, 2-bit counters; power of 2
BTB_ENTRIES, 16, direct-mapped entries; power of 2
BTB_TAG_W, 8, tag bits taken from pc above the index
GHR_W, 6, global history length; must be <= log2(BHT_ENTRIES)
GSHARE_EN, 1, 1 = index is pc XOR GHR; 0 = pc only (bimodal)
RAS_DEPTH, 8, return stack entries; power of 2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
prd_vld_i  in  1  IF instruction valid; gates speculative updates
pc_i  in  ADDR_W  fetch pc
dec_bxx_i, dec_jal_i, dec_jalr_i, dec_call_i, dec_ret_i  in  1 each  mini-decode flags
dec_imm_i  in  ADDR_W  sign-extended branch/jal immediate
upd_vld_i  in  1  EX resolution valid
upd_tkn_i  in  1  resolved direction
upd_mis_i  in  1  resolved mispredict
upd_type_i  in  BR_TYPE_W  resolved branch type
upd_src_pc_i  in  ADDR_W  branch pc
upd_tgt_pc_i  in  ADDR_W  resolved target
upd_sat_cnt_i  in  2  counter value captured at predict time
upd_ghr_i  in  GHR_W  GHR checkpoint captured at predict time
upd_ras_ptr_i  in  log2(RAS_DEPTH)  RAS top-pointer checkpoint
upd_ras_cnt_i  in  log2(RAS_DEPTH)+1  RAS occupancy checkpoint
bpu_prd_tkn_o  out  1  predicted taken
bpu_prd_pc_o  out  ADDR_W  predicted target
bpu_prd_sat_cnt_o  out  2  counter read; travels with the instruction
bpu_prd_ghr_o  out  GHR_W  GHR before this instruction; checkpoint
bpu_prd_ras_ptr_o  out  log2(RAS_DEPTH)  RAS ptr before this instruction
bpu_prd_ras_cnt_o  out  log2(RAS_DEPTH)+1  RAS count before this instruction

Behaviour:
- Reset (sync, rst_i=1 at edge):
  - all BHT counters = 2'b01
  - all BTB valid bits = 0
  - GHR = 0; RAS ptr = 0, count = 0
  - First cycle after reset: bpu_prd_tkn_o=0 for bxx; sat_cnt_o=01; ghr_o=0; ras_ptr_o=0; ras_cnt_o=0.
  - Reset asserted mid-operation discards all speculative state identically.
- Indexing:
  - bht_idx = pc[log2(BHT_ENTRIES)+1:2] XOR (GSHARE_EN ? zero-extended GHR : 0).
  - btb_idx = pc[log2(BTB_ENTRIES)+1:2]; tag = the next BTB_TAG_W bits.
- Prediction (combinational, zero latency):
  - bxx: tkn = cnt[1]; pc = pc_i+dec_imm_i.
  - jal: tkn = 1; pc = pc_i+dec_imm_i.
  - ret: if RAS count>0, tkn = 1, pc = RAS top; else tkn = BTB hit, pc = BTB target.
  - other jalr: tkn = BTB hit; pc = BTB target.
  - no flag set: tkn = 0; pc = pc_i+4.
- Speculative update (edge, prd_vld_i=1 and no mispredict this cycle):
  - bxx: GHR = {GHR[GHR_W-2:0], cnt[1]}.
  - ret: pop (ptr-1, count-1) when count>0; no pop when empty.
  - call: push pc_i+4 at ptr+1, ptr+1, count = min(count+1, RAS_DEPTH). Full overwrites the oldest entry (ptr wraps mod RAS_DEPTH).
  - call and ret together: pop then push, so the top entry is replaced; count unchanged when count>0.
- Resolution update (edge, upd_vld_i=1):
  - bxx: BHT[idx(upd_src_pc_i, upd_ghr_i)] = saturating inc (tkn) or dec of upd_sat_cnt_i. 11 stays 11, 00 stays 00.
  - Any type with upd_tkn_i=1 and type != ret: BTB[idx] = {valid=1, tag, upd_tgt_pc_i} (overwrite).
- Mispredict recovery (upd_vld_i and upd_mis_i):
  - GHR = bxx ? {upd_ghr_i[GHR_W-2:0], upd_tkn_i} : upd_ghr_i.
  - RAS ptr/count restored from checkpoint, then the resolved instruction's own call/ret action is reapplied.
  - Push value for a reapplied call is upd_src_pc_i+4.
  - Recovery takes priority over the same-cycle speculative update, which is dropped.
  - BHT/BTB write and prediction read of the same entry in one cycle: the read returns the old value (write-after-read).
- All pc arithmetic is modulo 2^ADDR_W.

Decomposition:
- Shared package (k423_defines):
  - BR_TYPE_W=3
  - BR_TYPE_BXX=0, BR_TYPE_JAL=1, BR_TYPE_JALR=2, BR_TYPE_CALL=3, BR_TYPE_RET=4
  - SAT_CNT reset constant 2'b01
- Sub-module k423_if_bpu_ras_ckpt holds the RAS storage, ptr/count, push/pop/restore priority, and checkpoint outputs.
- BHT, BTB and GHR stay inline.

Test Plan:
- Reset, then bxx at pc=0x100, imm=0x40 → tkn=0, pc_o=0x140, sat_cnt_o=01, ghr_o=0. Resolve taken, no mispredict → BHT entry becomes 10. Same pc with ghr=0 → tkn=1.
- Saturation: four taken resolutions from 01 → counter sticks at 11. Five not-taken → counter sticks at 00.
- RAS overflow with RAS_DEPTH=8: nine calls at pc=0x1000+4k (k=0..8), then nine rets. First eight rets return 0x1024…0x1008 in order. Ninth ret has count=0 → falls back to BTB (miss → tkn=0).
- Mispredict recovery: call at 0x200 (ptr 0→1), then speculative ret and call. Resolve bxx mispredict with checkpoint ptr=1/cnt=1 and tkn=1 → ptr=1, cnt=1, top=0x204, GHR = {ckpt, 1}. Same-cycle speculative push is dropped.
- Indirect jalr: jalr at 0x300 resolves taken to 0x8000 → next jalr at 0x300 gives tkn=1, pc_o=0x8000. Aliasing pc with a different tag → miss, tkn=0.
- GSHARE_EN=0 build: identical pc with differing GHR reads the same counter. GSHARE_EN=1: ghr 000001 vs 000000 reads different entries.

Source files
------------

// File: rtl/k423_if_bpu_v2_pkg.sv
//==============================================================================
// Module      : k423_defines (package)
// Description : Shared branch-type encodings and counter helpers for the BPU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package k423_defines;

    localparam int BR_TYPE_W = 3;

    localparam logic [BR_TYPE_W-1:0] BR_TYPE_BXX  = 3'd0;
    localparam logic [BR_TYPE_W-1:0] BR_TYPE_JAL  = 3'd1;
    localparam logic [BR_TYPE_W-1:0] BR_TYPE_JALR = 3'd2;
    localparam logic [BR_TYPE_W-1:0] BR_TYPE_CALL = 3'd3;
    localparam logic [BR_TYPE_W-1:0] BR_TYPE_RET  = 3'd4;

    localparam logic [1:0] SAT_CNT_RST = 2'b01;

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic tkn);
        if (tkn) begin
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
        end
        return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/k423_if_bpu_v2_if.sv
//==============================================================================
// Module      : k423_if_bpu_v2_if
// Description : Fetch-side prediction and EX-side resolution bundle of the BPU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface k423_if_bpu_v2_if #(
    parameter int ADDR_W    = 32,
    parameter int GHR_W     = 6,
    parameter int RAS_DEPTH = 8
);
    import k423_defines::*;

    localparam int c_ptr_w = $clog2(RAS_DEPTH);

    logic                  prd_vld_i;
    logic [ADDR_W-1:0]     pc_i;
    logic                  dec_bxx_i;
    logic                  dec_jal_i;
    logic                  dec_jalr_i;
    logic                  dec_call_i;
    logic                  dec_ret_i;
    logic [ADDR_W-1:0]     dec_imm_i;

    logic                  upd_vld_i;
    logic                  upd_tkn_i;
    logic                  upd_mis_i;
    logic [BR_TYPE_W-1:0]  upd_type_i;
    logic [ADDR_W-1:0]     upd_src_pc_i;
    logic [ADDR_W-1:0]     upd_tgt_pc_i;
    logic [1:0]            upd_sat_cnt_i;
    logic [GHR_W-1:0]      upd_ghr_i;
    logic [c_ptr_w-1:0]    upd_ras_ptr_i;
    logic [c_ptr_w:0]      upd_ras_cnt_i;

    logic                  bpu_prd_tkn_o;
    logic [ADDR_W-1:0]     bpu_prd_pc_o;
    logic [1:0]            bpu_prd_sat_cnt_o;
    logic [GHR_W-1:0]      bpu_prd_ghr_o;
    logic [c_ptr_w-1:0]    bpu_prd_ras_ptr_o;
    logic [c_ptr_w:0]      bpu_prd_ras_cnt_o;

    modport master (
        output prd_vld_i, pc_i, dec_bxx_i, dec_jal_i, dec_jalr_i, dec_call_i,
               dec_ret_i, dec_imm_i, upd_vld_i, upd_tkn_i, upd_mis_i, upd_type_i,
               upd_src_pc_i, upd_tgt_pc_i, upd_sat_cnt_i, upd_ghr_i,
               upd_ras_ptr_i, upd_ras_cnt_i,
        input  bpu_prd_tkn_o, bpu_prd_pc_o, bpu_prd_sat_cnt_o, bpu_prd_ghr_o,
               bpu_prd_ras_ptr_o, bpu_prd_ras_cnt_o
    );

    modport slave (
        input  prd_vld_i, pc_i, dec_bxx_i, dec_jal_i, dec_jalr_i, dec_call_i,
               dec_ret_i, dec_imm_i, upd_vld_i, upd_tkn_i, upd_mis_i, upd_type_i,
               upd_src_pc_i, upd_tgt_pc_i, upd_sat_cnt_i, upd_ghr_i,
               upd_ras_ptr_i, upd_ras_cnt_i,
        output bpu_prd_tkn_o, bpu_prd_pc_o, bpu_prd_sat_cnt_o, bpu_prd_ghr_o,
               bpu_prd_ras_ptr_o, bpu_prd_ras_cnt_o
    );

endinterface

`default_nettype wire

// File: rtl/k423_if_bpu_ras_ckpt.sv
//==============================================================================
// Module      : k423_if_bpu_ras_ckpt
// Description : Checkpointed return address stack; recovery overrides speculation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module k423_if_bpu_ras_ckpt #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_spec_vld,
    input  logic                           i_spec_push,
    input  logic                           i_spec_pop,
    input  logic [ADDR_W-1:0]              i_spec_val,
    input  logic                           i_rec_vld,
    input  logic [$clog2(RAS_DEPTH)-1:0]   i_rec_ptr,
    input  logic [$clog2(RAS_DEPTH):0]     i_rec_cnt,
    input  logic                           i_rec_push,
    input  logic                           i_rec_pop,
    input  logic [ADDR_W-1:0]              i_rec_val,
    output logic [ADDR_W-1:0]              o_top,
    output logic [$clog2(RAS_DEPTH)-1:0]   o_ptr,
    output logic [$clog2(RAS_DEPTH):0]     o_cnt
);

    localparam int                 c_ptr_w = $clog2(RAS_DEPTH);
    localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0]   r_stack [RAS_DEPTH];
    logic [c_ptr_w-1:0]  r_ptr;
    logic [c_ptr_w:0]    r_cnt;

    logic [c_ptr_w-1:0]  w_base_ptr, w_pop_ptr, w_nxt_ptr;
    logic [c_ptr_w:0]    w_base_cnt, w_pop_cnt, w_nxt_cnt;
    logic                w_push, w_pop;
    logic [ADDR_W-1:0]   w_val;

    // Pop is applied before push so a call+ret pair replaces the top entry.
    always_comb begin
        w_base_ptr = r_ptr;
        w_base_cnt = r_cnt;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_val      = i_spec_val;
        if (i_rec_vld) begin
            w_base_ptr = i_rec_ptr;
            w_base_cnt = i_rec_cnt;
            w_push     = i_rec_push;
            w_pop      = i_rec_pop;
            w_val      = i_rec_val;
        end else if (i_spec_vld) begin
            w_push     = i_spec_push;
            w_pop      = i_spec_pop;
        end

        w_pop_ptr = w_base_ptr;
        w_pop_cnt = w_base_cnt;
        if (w_pop && (w_base_cnt != '0)) begin
            w_pop_ptr = w_base_ptr - c_ptr_w'(1);
            w_pop_cnt = w_base_cnt - (c_ptr_w+1)'(1);
        end

        w_nxt_ptr = w_pop_ptr;
        w_nxt_cnt = w_pop_cnt;
        if (w_push) begin
            w_nxt_ptr = w_pop_ptr + c_ptr_w'(1);
            w_nxt_cnt = (w_pop_cnt == c_full) ? w_pop_cnt : w_pop_cnt + (c_ptr_w+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            r_ptr <= w_nxt_ptr;
            r_cnt <= w_nxt_cnt;
        end
    end

    // Storage is not reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack[w_nxt_ptr] <= w_val;
        end
    end

    assign o_top = r_stack[r_ptr];
    assign o_ptr = r_ptr;
    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/k423_if_bpu_v2.sv
//==============================================================================
// Module      : k423_if_bpu_v2
// Description : IF-stage predictor: gshare/bimodal BHT, tagged BTB, GHR, RAS.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module k423_if_bpu_v2 #(
    parameter int ADDR_W      = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int BTB_TAG_W   = 8,
    parameter int GHR_W       = 6,
    parameter int GSHARE_EN   = 1,
    parameter int RAS_DEPTH   = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    k423_if_bpu_v2_if.slave bus
);
    import k423_defines::*;

    localparam int c_bht_aw = $clog2(BHT_ENTRIES);
    localparam int c_btb_aw = $clog2(BTB_ENTRIES);
    localparam int c_ptr_w  = $clog2(RAS_DEPTH);

    logic [1:0]            r_bht     [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] r_btb_vld;
    logic [BTB_TAG_W-1:0]  r_btb_tag [BTB_ENTRIES];
    logic [ADDR_W-1:0]     r_btb_tgt [BTB_ENTRIES];
    logic [GHR_W-1:0]      r_ghr;

    logic [c_bht_aw-1:0]   w_hash_prd, w_hash_upd;
    logic [c_bht_aw-1:0]   w_bht_idx, w_upd_bht_idx;
    logic [1:0]            w_cnt;
    logic [c_btb_aw-1:0]   w_btb_idx, w_upd_btb_idx;
    logic [BTB_TAG_W-1:0]  w_btb_tag, w_upd_btb_tag;
    logic                  w_btb_hit;
    logic [ADDR_W-1:0]     w_seq_pc, w_rel_pc, w_upd_seq_pc;
    logic                  w_rec, w_spec;
    logic                  w_prd_tkn;
    logic [ADDR_W-1:0]     w_prd_pc;
    logic [ADDR_W-1:0]     w_ras_top;
    logic [c_ptr_w-1:0]    w_ras_ptr;
    logic [c_ptr_w:0]      w_ras_cnt;

    if (GSHARE_EN != 0) begin : g_gshare
        assign w_hash_prd = c_bht_aw'(r_ghr);
        assign w_hash_upd = c_bht_aw'(bus.upd_ghr_i);
    end else begin : g_bimodal
        assign w_hash_prd = '0;
        assign w_hash_upd = '0;
    end

    assign w_bht_idx     = bus.pc_i[c_bht_aw+1:2] ^ w_hash_prd;
    assign w_upd_bht_idx = bus.upd_src_pc_i[c_bht_aw+1:2] ^ w_hash_upd;
    assign w_cnt         = r_bht[w_bht_idx];

    assign w_btb_idx     = bus.pc_i[c_btb_aw+1:2];
    assign w_btb_tag     = bus.pc_i[c_btb_aw+2+BTB_TAG_W-1:c_btb_aw+2];
    assign w_upd_btb_idx = bus.upd_src_pc_i[c_btb_aw+1:2];
    assign w_upd_btb_tag = bus.upd_src_pc_i[c_btb_aw+2+BTB_TAG_W-1:c_btb_aw+2];
    assign w_btb_hit     = r_btb_vld[w_btb_idx] && (r_btb_tag[w_btb_idx] == w_btb_tag);

    assign w_seq_pc      = bus.pc_i + ADDR_W'(4);
    assign w_rel_pc      = bus.pc_i + bus.dec_imm_i;
    assign w_upd_seq_pc  = bus.upd_src_pc_i + ADDR_W'(4);

    // A mispredict repair wins over whatever IF is speculating this cycle.
    assign w_rec  = bus.upd_vld_i && bus.upd_mis_i;
    assign w_spec = bus.prd_vld_i && !w_rec;

    always_comb begin
        w_prd_tkn = 1'b0;
        w_prd_pc  = w_seq_pc;
        if (bus.dec_bxx_i) begin
            w_prd_tkn = w_cnt[1];
            w_prd_pc  = w_rel_pc;
        end else if (bus.dec_jal_i) begin
            w_prd_tkn = 1'b1;
            w_prd_pc  = w_rel_pc;
        end else if (bus.dec_ret_i && (w_ras_cnt != '0)) begin
            w_prd_tkn = 1'b1;
            w_prd_pc  = w_ras_top;
        end else if (bus.dec_ret_i || bus.dec_jalr_i || bus.dec_call_i) begin
            w_prd_tkn = w_btb_hit;
            w_prd_pc  = r_btb_tgt[w_btb_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= SAT_CNT_RST;
            end
        end else if (bus.upd_vld_i && (bus.upd_type_i == BR_TYPE_BXX)) begin
            r_bht[w_upd_bht_idx] <= sat_next(bus.upd_sat_cnt_i, bus.upd_tkn_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btb_vld <= '0;
        end else if (bus.upd_vld_i && bus.upd_tkn_i && (bus.upd_type_i != BR_TYPE_RET)) begin
            r_btb_vld[w_upd_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && bus.upd_vld_i && bus.upd_tkn_i && (bus.upd_type_i != BR_TYPE_RET)) begin
            r_btb_tag[w_upd_btb_idx] <= w_upd_btb_tag;
            r_btb_tgt[w_upd_btb_idx] <= bus.upd_tgt_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ghr <= '0;
        end else if (w_rec) begin
            r_ghr <= (bus.upd_type_i == BR_TYPE_BXX) ?
                     {bus.upd_ghr_i[GHR_W-2:0], bus.upd_tkn_i} : bus.upd_ghr_i;
        end else if (w_spec && bus.dec_bxx_i) begin
            r_ghr <= {r_ghr[GHR_W-2:0], w_cnt[1]};
        end
    end

    k423_if_bpu_ras_ckpt #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_spec_vld  (w_spec),
        .i_spec_push (bus.dec_call_i),
        .i_spec_pop  (bus.dec_ret_i),
        .i_spec_val  (w_seq_pc),
        .i_rec_vld   (w_rec),
        .i_rec_ptr   (bus.upd_ras_ptr_i),
        .i_rec_cnt   (bus.upd_ras_cnt_i),
        .i_rec_push  (bus.upd_type_i == BR_TYPE_CALL),
        .i_rec_pop   (bus.upd_type_i == BR_TYPE_RET),
        .i_rec_val   (w_upd_seq_pc),
        .o_top       (w_ras_top),
        .o_ptr       (w_ras_ptr),
        .o_cnt       (w_ras_cnt)
    );

    assign bus.bpu_prd_tkn_o     = w_prd_tkn;
    assign bus.bpu_prd_pc_o      = w_prd_pc;
    assign bus.bpu_prd_sat_cnt_o = w_cnt;
    assign bus.bpu_prd_ghr_o     = r_ghr;
    assign bus.bpu_prd_ras_ptr_o = w_ras_ptr;
    assign bus.bpu_prd_ras_cnt_o = w_ras_cnt;

endmodule

`default_nettype wire

// File: tb/tb_k423_if_bpu_v2.sv
//==============================================================================
// Module      : tb_k423_if_bpu_v2
// Description : Directed bench for k423_if_bpu_v2 (gshare and bimodal builds).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_k423_if_bpu_v2;
    import k423_defines::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    k423_if_bpu_v2_if #(.ADDR_W(32), .GHR_W(6), .RAS_DEPTH(8)) bus_g ();
    k423_if_bpu_v2_if #(.ADDR_W(32), .GHR_W(6), .RAS_DEPTH(8)) bus_b ();

    k423_if_bpu_v2 #(.GSHARE_EN(1)) dut (.clk_i(clk), .rst_i(rst), .bus(bus_g));
    k423_if_bpu_v2 #(.GSHARE_EN(0)) dut_bim (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    assign bus_b.prd_vld_i     = bus_g.prd_vld_i;
    assign bus_b.pc_i          = bus_g.pc_i;
    assign bus_b.dec_bxx_i     = bus_g.dec_bxx_i;
    assign bus_b.dec_jal_i     = bus_g.dec_jal_i;
    assign bus_b.dec_jalr_i    = bus_g.dec_jalr_i;
    assign bus_b.dec_call_i    = bus_g.dec_call_i;
    assign bus_b.dec_ret_i     = bus_g.dec_ret_i;
    assign bus_b.dec_imm_i     = bus_g.dec_imm_i;
    assign bus_b.upd_vld_i     = bus_g.upd_vld_i;
    assign bus_b.upd_tkn_i     = bus_g.upd_tkn_i;
    assign bus_b.upd_mis_i     = bus_g.upd_mis_i;
    assign bus_b.upd_type_i    = bus_g.upd_type_i;
    assign bus_b.upd_src_pc_i  = bus_g.upd_src_pc_i;
    assign bus_b.upd_tgt_pc_i  = bus_g.upd_tgt_pc_i;
    assign bus_b.upd_sat_cnt_i = bus_g.upd_sat_cnt_i;
    assign bus_b.upd_ghr_i     = bus_g.upd_ghr_i;
    assign bus_b.upd_ras_ptr_i = bus_g.upd_ras_ptr_i;
    assign bus_b.upd_ras_cnt_i = bus_g.upd_ras_cnt_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_up [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
    logic [1:0] exp_dn [5] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
    logic [1:0] feed;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus_g.prd_vld_i     = 1'b0;
        bus_g.pc_i          = '0;
        bus_g.dec_bxx_i     = 1'b0;
        bus_g.dec_jal_i     = 1'b0;
        bus_g.dec_jalr_i    = 1'b0;
        bus_g.dec_call_i    = 1'b0;
        bus_g.dec_ret_i     = 1'b0;
        bus_g.dec_imm_i     = '0;
        bus_g.upd_vld_i     = 1'b0;
        bus_g.upd_tkn_i     = 1'b0;
        bus_g.upd_mis_i     = 1'b0;
        bus_g.upd_type_i    = BR_TYPE_BXX;
        bus_g.upd_src_pc_i  = '0;
        bus_g.upd_tgt_pc_i  = '0;
        bus_g.upd_sat_cnt_i = 2'b00;
        bus_g.upd_ghr_i     = '0;
        bus_g.upd_ras_ptr_i = '0;
        bus_g.upd_ras_cnt_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [2:0] typ, input logic [31:0] src, input logic [31:0] tgt,
                           input logic tkn, input logic mis, input logic [1:0] sat,
                           input logic [5:0] ghr, input logic [2:0] rptr, input logic [3:0] rcnt);
        bus_g.upd_vld_i     = 1'b1;
        bus_g.upd_type_i    = typ;
        bus_g.upd_src_pc_i  = src;
        bus_g.upd_tgt_pc_i  = tgt;
        bus_g.upd_tkn_i     = tkn;
        bus_g.upd_mis_i     = mis;
        bus_g.upd_sat_cnt_i = sat;
        bus_g.upd_ghr_i     = ghr;
        bus_g.upd_ras_ptr_i = rptr;
        bus_g.upd_ras_cnt_i = rcnt;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state; resolving the same entry this cycle must not change the read
        bus_g.dec_bxx_i = 1'b1; bus_g.pc_i = 32'h100; bus_g.dec_imm_i = 32'h40;
        resolve(BR_TYPE_BXX, 32'h100, 32'h140, 1'b1, 1'b0, 2'b01, 6'd0, 3'd0, 4'd0);
        #2;
        check("rst_tkn",     bus_g.bpu_prd_tkn_o,     0);
        check("rst_pc",      bus_g.bpu_prd_pc_o,      32'h140);
        check("rst_sat",     bus_g.bpu_prd_sat_cnt_o, 2'b01);
        check("rst_ghr",     bus_g.bpu_prd_ghr_o,     0);
        check("rst_ras_ptr", bus_g.bpu_prd_ras_ptr_o, 0);
        check("rst_ras_cnt", bus_g.bpu_prd_ras_cnt_o, 0);
        tick();
        idle();
        bus_g.dec_bxx_i = 1'b1; bus_g.pc_i = 32'h100; bus_g.dec_imm_i = 32'h40;
        #2;
        check("bht_trained_tkn", bus_g.bpu_prd_tkn_o,     1);
        check("bht_trained_sat", bus_g.bpu_prd_sat_cnt_o, 2'b10);

        // saturation on a fresh counter
        feed = 2'b01;
        for (int i = 0; i < 4; i++) begin
            idle();
            resolve(BR_TYPE_BXX, 32'h104, 32'h0, 1'b1, 1'b0, feed, 6'd0, 3'd0, 4'd0);
            tick();
            idle();
            bus_g.dec_bxx_i = 1'b1; bus_g.pc_i = 32'h104;
            #2;
            check("sat_up", bus_g.bpu_prd_sat_cnt_o, exp_up[i]);
            feed = exp_up[i];
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            resolve(BR_TYPE_BXX, 32'h104, 32'h0, 1'b0, 1'b0, feed, 6'd0, 3'd0, 4'd0);
            tick();
            idle();
            bus_g.dec_bxx_i = 1'b1; bus_g.pc_i = 32'h104;
            #2;
            check("sat_dn", bus_g.bpu_prd_sat_cnt_o, exp_dn[i]);
            feed = exp_dn[i];
        end
        check("sat_dn_tkn", bus_g.bpu_prd_tkn_o, 0);

        // RAS overflow: nine calls then nine returns
        for (int k = 0; k < 9; k++) begin
            idle();
            bus_g.prd_vld_i = 1'b1; bus_g.dec_jal_i = 1'b1; bus_g.dec_call_i = 1'b1;
            bus_g.pc_i = 32'h1000 + 32'(4 * k); bus_g.dec_imm_i = 32'h100;
            #2;
            check("call_cnt", bus_g.bpu_prd_ras_cnt_o, (k < 8) ? k : 8);
            tick();
        end
        idle();
        #2;
        check("full_cnt", bus_g.bpu_prd_ras_cnt_o, 8);
        check("full_ptr", bus_g.bpu_prd_ras_ptr_o, 1);
        for (int i = 0; i < 8; i++) begin
            idle();
            bus_g.prd_vld_i = 1'b1; bus_g.dec_ret_i = 1'b1; bus_g.pc_i = 32'h2000;
            #2;
            check("ret_tkn", bus_g.bpu_prd_tkn_o, 1);
            check("ret_pc",  bus_g.bpu_prd_pc_o,  32'h1024 - 32'(4 * i));
            tick();
        end
        idle();
        bus_g.prd_vld_i = 1'b1; bus_g.dec_ret_i = 1'b1; bus_g.pc_i = 32'h2000;
        #2;
        check("ret_empty_tkn", bus_g.bpu_prd_tkn_o, 0);
        tick();
        idle();
        #2;
        check("ret_empty_cnt", bus_g.bpu_prd_ras_cnt_o, 0);

        // reset mid-operation with a call in flight
        bus_g.prd_vld_i = 1'b1; bus_g.dec_jal_i = 1'b1; bus_g.dec_call_i = 1'b1; bus_g.pc_i = 32'h900;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        bus_g.dec_bxx_i = 1'b1; bus_g.pc_i = 32'h104;
        #2;
        check("rst2_ptr", bus_g.bpu_prd_ras_ptr_o, 0);
        check("rst2_cnt", bus_g.bpu_prd_ras_cnt_o, 0);
        check("rst2_sat", bus_g.bpu_prd_sat_cnt_o, 2'b01);

        // mispredict recovery
        idle();
        bus_g.prd_vld_i = 1'b1; bus_g.dec_jal_i = 1'b1; bus_g.dec_call_i = 1'b1; bus_g.pc_i = 32'h200;
        tick();
        idle();
        bus_g.prd_vld_i = 1'b1; bus_g.dec_ret_i = 1'b1; bus_g.pc_i = 32'h300;
        #2;
        check("rec_call_ptr", bus_g.bpu_prd_ras_ptr_o, 1);
        check("rec_ret_pc",   bus_g.bpu_prd_pc_o,      32'h204);
        tick();
        idle();
        bus_g.prd_vld_i = 1'b1; bus_g.dec_jal_i = 1'b1; bus_g.dec_call_i = 1'b1; bus_g.pc_i = 32'h400;
        resolve(BR_TYPE_BXX, 32'h500, 32'h520, 1'b1, 1'b1, 2'b01, 6'b100101, 3'd1, 4'd1);
        #2;
        check("rec_pre_cnt", bus_g.bpu_prd_ras_cnt_o, 0);
        tick();
        idle();
        bus_g.dec_ret_i = 1'b1; bus_g.pc_i = 32'h300;
        #2;
        check("rec_ptr", bus_g.bpu_prd_ras_ptr_o, 1);
        check("rec_cnt", bus_g.bpu_prd_ras_cnt_o, 1);
        check("rec_ghr", bus_g.bpu_prd_ghr_o,     6'b001011);
        check("rec_top", bus_g.bpu_prd_pc_o,      32'h204);

        idle();
        bus_g.prd_vld_i = 1'b1; bus_g.dec_bxx_i = 1'b1; bus_g.pc_i = 32'h800;
        #2;
        check("spec_bxx_tkn", bus_g.bpu_prd_tkn_o, 0);
        tick();
        idle();
        #2;
        check("spec_ghr", bus_g.bpu_prd_ghr_o, 6'b010110);

        resolve(BR_TYPE_CALL, 32'h600, 32'h9000, 1'b1, 1'b1, 2'b01, 6'd0, 3'd1, 4'd1);
        tick();
        idle();
        bus_g.dec_ret_i = 1'b1; bus_g.pc_i = 32'h300;
        #2;
        check("rec_call_ptr2", bus_g.bpu_prd_ras_ptr_o, 2);
        check("rec_call_cnt2", bus_g.bpu_prd_ras_cnt_o, 2);
        check("rec_call_ghr",  bus_g.bpu_prd_ghr_o,     0);
        check("rec_call_top",  bus_g.bpu_prd_pc_o,      32'h604);
        resolve(BR_TYPE_RET, 32'h700, 32'h604, 1'b1, 1'b1, 2'b01, 6'd0, 3'd2, 4'd2);
        tick();
        idle();
        bus_g.dec_ret_i = 1'b1; bus_g.pc_i = 32'h300;
        #2;
        check("rec_ret_cnt", bus_g.bpu_prd_ras_cnt_o, 1);
        check("rec_ret_top", bus_g.bpu_prd_pc_o,      32'h204);

        // indirect jalr through the BTB, then a same-index different-tag alias
        idle();
        resolve(BR_TYPE_JALR, 32'h300, 32'h8000, 1'b1, 1'b0, 2'b01, 6'd0, 3'd0, 4'd0);
        tick();
        idle();
        bus_g.dec_jalr_i = 1'b1; bus_g.pc_i = 32'h300;
        #2;
        check("btb_hit_tkn", bus_g.bpu_prd_tkn_o, 1);
        check("btb_hit_pc",  bus_g.bpu_prd_pc_o,  32'h8000);
        bus_g.pc_i = 32'h700;
        #1;
        check("btb_alias_tkn", bus_g.bpu_prd_tkn_o, 0);

        // pc arithmetic wraps
        idle();
        bus_g.pc_i = 32'hFFFF_FFFC;
        #1;
        check("seq_wrap_tkn", bus_g.bpu_prd_tkn_o, 0);
        check("seq_wrap_pc",  bus_g.bpu_prd_pc_o,  0);
        bus_g.dec_bxx_i = 1'b1; bus_g.pc_i = 32'h10; bus_g.dec_imm_i = 32'hFFFF_FFF0;
        #1;
        check("rel_wrap_pc", bus_g.bpu_prd_pc_o, 0);

        // gshare vs bimodal indexing
        tick();
        idle();
        resolve(BR_TYPE_BXX, 32'h40, 32'h0, 1'b1, 1'b0, 2'b01, 6'd0, 3'd1, 4'd1);
        tick();
        idle();
        bus_g.dec_bxx_i = 1'b1; bus_g.pc_i = 32'h40;
        #2;
        check("gs_g0_sat",  bus_g.bpu_prd_sat_cnt_o, 2'b10);
        check("bim_g0_sat", bus_b.bpu_prd_sat_cnt_o, 2'b10);
        resolve(BR_TYPE_JAL, 32'h50, 32'h0, 1'b0, 1'b1, 2'b01, 6'b000001, 3'd1, 4'd1);
        tick();
        idle();
        bus_g.dec_bxx_i = 1'b1; bus_g.pc_i = 32'h40;
        #2;
        check("gs_g1_ghr",  bus_g.bpu_prd_ghr_o,     6'b000001);
        check("gs_g1_sat",  bus_g.bpu_prd_sat_cnt_o, 2'b01);
        check("gs_g1_tkn",  bus_g.bpu_prd_tkn_o,     0);
        check("bim_g1_sat", bus_b.bpu_prd_sat_cnt_o, 2'b10);
        check("bim_g1_tkn", bus_b.bpu_prd_tkn_o,     1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
